// File: rtl/ws2812b_pkg.sv
// Shared types, 12 MHz timing defaults and the channel scaling helper for the
// WS2812B/SK6812 frame streamer.
package ws2812b_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PREFETCH,
        SEND,
        LATCH
    } stream_state_t;

    localparam int DEF_BIT_CYCLES   = 15;
    localparam int DEF_T0H_CYCLES   = 4;
    localparam int DEF_T1H_CYCLES   = 9;
    localparam int DEF_RESET_CYCLES = 3600;

    localparam int ORDER_GRB = 0;
    localparam int ORDER_RGB = 1;

    // (ch * (brightness + 1)) >> 8: 255 is a pass-through, 0 blanks the channel.
    function automatic logic [7:0] scale8(input logic [7:0] ch, input logic [7:0] brightness);
        logic [8:0]  mult;
        logic [16:0] prod;
        mult = {1'b0, brightness} + 9'd1;
        prod = 17'(ch) * 17'(mult);
        return 8'(prod >> 8);
    endfunction

endpackage

// File: rtl/ws2812b_bit_timer.sv
// Produces one BIT_CYCLES-long WS2812B bit per start strobe; a strobe on the
// bit_end cycle chains the next bit with no gap.
module ws2812b_bit_timer #(
    parameter int BIT_CYCLES = 15,
    parameter int T0H_CYCLES = 4,
    parameter int T1H_CYCLES = 9
) (
    input  logic clk,
    input  logic rst,
    input  logic bit_val,
    input  logic bit_start,
    output logic dout,
    output logic bit_end
);

    localparam int CW = $clog2(BIT_CYCLES);

    logic [CW-1:0] cyc_q, cyc_d;
    logic          active_q, active_d;
    logic          bit_q, bit_d;
    logic          dout_q, dout_d;

    assign bit_end = active_q && (cyc_q == CW'(BIT_CYCLES - 1));
    assign dout    = dout_q;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        cyc_d    = cyc_q;
        active_d = active_q;
        bit_d    = bit_q;
        if (bit_start) begin
            cyc_d    = '0;
            active_d = 1'b1;
            bit_d    = bit_val;
        end else if (bit_end) begin
            cyc_d    = '0;
            active_d = 1'b0;
        end else if (active_q) begin
            cyc_d = cyc_q + 1'b1;
        end
        // dout is registered from the next-state values so the pin never glitches.
        dout_d = active_d && (cyc_d < (bit_d ? CW'(T1H_CYCLES) : CW'(T0H_CYCLES)));
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q    <= '0;
            active_q <= 1'b0;
            bit_q    <= 1'b0;
            dout_q   <= 1'b0;
        end else begin
            cyc_q    <= cyc_d;
            active_q <= active_d;
            bit_q    <= bit_d;
            dout_q   <= dout_d;
        end
    end

endmodule

// File: rtl/ws2812b_frame_streamer.sv
// Fetches NUM_PIXELS words, scales and reorders them, and streams them gaplessly
// to a WS2812B/SK6812 chain followed by a latch interval.
module ws2812b_frame_streamer
    import ws2812b_pkg::*;
#(
    parameter int NUM_PIXELS   = 64,
    parameter int NUM_CHANNELS = 3,
    parameter int COLOR_ORDER  = ORDER_GRB,
    parameter int BIT_CYCLES   = DEF_BIT_CYCLES,
    parameter int T0H_CYCLES   = DEF_T0H_CYCLES,
    parameter int T1H_CYCLES   = DEF_T1H_CYCLES,
    parameter int RESET_CYCLES = DEF_RESET_CYCLES,
    parameter int RD_LATENCY   = 1,
    localparam int AW = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1,
    localparam int PW = 8 * NUM_CHANNELS
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          ready,
    output logic          done,
    input  logic [7:0]    brightness,
    output logic [AW-1:0] pix_addr,
    output logic          pix_rd_en,
    input  logic [PW-1:0] pix_rdata,
    output logic          dout
);

    localparam int BW = $clog2(PW);
    localparam int LW = $clog2(RESET_CYCLES + 1);

    if (!(T0H_CYCLES < T1H_CYCLES && T1H_CYCLES < BIT_CYCLES)) begin : g_bad_bit_timing
        $error("ws2812b_frame_streamer: need T0H_CYCLES < T1H_CYCLES < BIT_CYCLES");
    end
    if (RD_LATENCY < 1 || RD_LATENCY > 4 || RD_LATENCY + 2 > PW * BIT_CYCLES) begin : g_bad_latency
        $error("ws2812b_frame_streamer: RD_LATENCY out of range");
    end
    if (NUM_CHANNELS != 3 && NUM_CHANNELS != 4) begin : g_bad_channels
        $error("ws2812b_frame_streamer: NUM_CHANNELS must be 3 or 4");
    end

    stream_state_t   state_q, state_d;
    logic [LW-1:0]   cnt_q, cnt_d;
    logic            frame_q, frame_d;
    logic            done_q, done_d;
    logic [7:0]      bright_q, bright_d;
    logic            rd_en_q, rd_en_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [AW-1:0]   pix_idx_q, pix_idx_d;
    logic [BW-1:0]   bit_idx_q, bit_idx_d;
    logic [RD_LATENCY-1:0] vld_q, vld_d;
    logic            stage_vld_q, stage_vld_d;
    logic [PW-1:0]   stage_q, stage_d;
    logic [PW-1:0]   shift_q, shift_d;
    logic [PW-1:0]   scaled, wire_word;
    logic            bit_start, bit_val, bit_end;

    assign ready     = (state_q == IDLE);
    assign done      = done_q;
    assign pix_addr  = addr_q;
    assign pix_rd_en = rd_en_q;

    always_comb begin
        scaled = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            scaled[c*8 +: 8] = scale8(pix_rdata[c*8 +: 8], bright_q);
        end
        if (COLOR_ORDER == ORDER_GRB) begin
            wire_word = {scaled[PW-9 -: 8], scaled[PW-1 -: 8], scaled[PW-17:0]};
        end else begin
            wire_word = scaled;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        frame_d     = frame_q;
        done_d      = 1'b0;
        bright_d    = bright_q;
        rd_en_d     = 1'b0;
        addr_d      = addr_q;
        pix_idx_d   = pix_idx_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        stage_d     = stage_q;
        stage_vld_d = stage_vld_q;
        vld_d       = RD_LATENCY'({vld_q, rd_en_q});
        bit_start   = 1'b0;
        bit_val     = shift_q[PW-1];

        if (vld_q[RD_LATENCY-1]) begin
            stage_d     = wire_word;
            stage_vld_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = PREFETCH;
                    bright_d  = brightness;
                    addr_d    = '0;
                    rd_en_d   = 1'b1;
                    pix_idx_d = '0;
                end
            end
            PREFETCH: begin
                if (stage_vld_q) begin
                    state_d     = SEND;
                    bit_start   = 1'b1;
                    bit_val     = stage_q[PW-1];
                    shift_d     = stage_q << 1;
                    stage_vld_d = 1'b0;
                    bit_idx_d   = '0;
                    pix_idx_d   = '0;
                    if (NUM_PIXELS > 1) begin
                        rd_en_d = 1'b1;
                        addr_d  = AW'(1);
                    end
                end
            end
            SEND: begin
                if (bit_end) begin
                    if (bit_idx_q != BW'(PW - 1)) begin
                        bit_start = 1'b1;
                        shift_d   = shift_q << 1;
                        bit_idx_d = bit_idx_q + 1'b1;
                    end else if (pix_idx_q != AW'(NUM_PIXELS - 1)) begin
                        // Pixel boundary: the staged word goes straight onto the wire.
                        bit_start   = 1'b1;
                        bit_val     = stage_q[PW-1];
                        shift_d     = stage_q << 1;
                        stage_vld_d = 1'b0;
                        bit_idx_d   = '0;
                        pix_idx_d   = pix_idx_q + 1'b1;
                        if (int'(pix_idx_q) + 2 < NUM_PIXELS) begin
                            rd_en_d = 1'b1;
                            addr_d  = pix_idx_q + AW'(2);
                        end
                    end else begin
                        state_d = LATCH;
                        cnt_d   = '0;
                        frame_d = 1'b1;
                    end
                end
            end
            LATCH: begin
                if (cnt_q == LW'(RESET_CYCLES - 1)) begin
                    state_d = IDLE;
                    done_d  = frame_q;
                    frame_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = LATCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LATCH;
            cnt_q       <= '0;
            frame_q     <= 1'b0;
            done_q      <= 1'b0;
            bright_q    <= '0;
            rd_en_q     <= 1'b0;
            addr_q      <= '0;
            pix_idx_q   <= '0;
            bit_idx_q   <= '0;
            vld_q       <= '0;
            stage_vld_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            frame_q     <= frame_d;
            done_q      <= done_d;
            bright_q    <= bright_d;
            rd_en_q     <= rd_en_d;
            addr_q      <= addr_d;
            pix_idx_q   <= pix_idx_d;
            bit_idx_q   <= bit_idx_d;
            vld_q       <= vld_d;
            stage_vld_q <= stage_vld_d;
        end
    end

    // NOTE: pure datapath registers are not reset; their valid flags above are.
    always_ff @(posedge clk) begin
        stage_q <= stage_d;
        shift_q <= shift_d;
    end

    ws2812b_bit_timer #(
        .BIT_CYCLES (BIT_CYCLES),
        .T0H_CYCLES (T0H_CYCLES),
        .T1H_CYCLES (T1H_CYCLES)
    ) u_bit_timer (
        .clk       (clk),
        .rst       (rst),
        .bit_val   (bit_val),
        .bit_start (bit_start),
        .dout      (dout),
        .bit_end   (bit_end)
    );

endmodule

// File: tb/tb_ws2812b_frame_streamer.sv
// Directed bench: three streamer configurations share one clock; a negedge
// monitor decodes the selected dout line into bit widths and rise times.
module tb_ws2812b_frame_streamer;

    localparam int MAXB = 4096;

    logic clk;
    int   errors = 0;
    int   checks = 0;
    int   sel    = 0;

    // a: 2 px RGB/GRB lat 1; b: 8 px lat 4; c: 2 px RGBW, RGB order
    logic        rst_a = 1, start_a = 0, ready_a, done_a, rd_a, dout_a;
    logic [7:0]  bright_a = 0;
    logic [0:0]  addr_a;
    logic [23:0] rdata_a;
    logic        rst_b = 1, start_b = 0, ready_b, done_b, rd_b, dout_b;
    logic [7:0]  bright_b = 0;
    logic [2:0]  addr_b;
    logic [23:0] rdata_b;
    logic        rst_c = 1, start_c = 0, ready_c, done_c, rd_c, dout_c;
    logic [7:0]  bright_c = 0;
    logic [0:0]  addr_c;
    logic [31:0] rdata_c;

    logic [23:0] mem_a [2];
    logic [23:0] mem_b [8];
    logic [31:0] mem_c [2];
    logic [3:0]  vp_a, vp_b, vp_c;
    int          ap_a [4];
    int          ap_b [4];
    int          ap_c [4];

    ws2812b_frame_streamer #(.NUM_PIXELS(2)) dut_a (
        .clk(clk), .rst(rst_a), .start(start_a), .ready(ready_a), .done(done_a),
        .brightness(bright_a), .pix_addr(addr_a), .pix_rd_en(rd_a),
        .pix_rdata(rdata_a), .dout(dout_a));

    ws2812b_frame_streamer #(.NUM_PIXELS(8), .RD_LATENCY(4)) dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .ready(ready_b), .done(done_b),
        .brightness(bright_b), .pix_addr(addr_b), .pix_rd_en(rd_b),
        .pix_rdata(rdata_b), .dout(dout_b));

    ws2812b_frame_streamer #(.NUM_PIXELS(2), .NUM_CHANNELS(4), .COLOR_ORDER(1)) dut_c (
        .clk(clk), .rst(rst_c), .start(start_c), .ready(ready_c), .done(done_c),
        .brightness(bright_c), .pix_addr(addr_c), .pix_rd_en(rd_c),
        .pix_rdata(rdata_c), .dout(dout_c));

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Pixel stores: data is only valid exactly RD_LATENCY cycles after the strobe.
    always @(posedge clk) begin
        vp_a <= {vp_a[2:0], rd_a};
        vp_b <= {vp_b[2:0], rd_b};
        vp_c <= {vp_c[2:0], rd_c};
        ap_a[0] <= int'(addr_a);
        ap_b[0] <= int'(addr_b);
        ap_c[0] <= int'(addr_c);
        for (int i = 3; i > 0; i--) begin
            ap_a[i] <= ap_a[i-1];
            ap_b[i] <= ap_b[i-1];
            ap_c[i] <= ap_c[i-1];
        end
    end
    assign rdata_a = (vp_a[0] === 1'b1) ? mem_a[ap_a[0] % 2] : 24'h5A5A5A;
    assign rdata_b = (vp_b[3] === 1'b1) ? mem_b[ap_b[3] % 8] : 24'h5A5A5A;
    assign rdata_c = (vp_c[0] === 1'b1) ? mem_c[ap_c[0] % 2] : 32'h5A5A5A5A;

    logic dout_sel, done_sel;
    assign dout_sel = (sel == 0) ? dout_a : (sel == 1) ? dout_b : dout_c;
    assign done_sel = (sel == 0) ? done_a : (sel == 1) ? done_b : done_c;

    int mon_cyc = 0, mon_n = 0, mon_hi = 0, mon_rise_cyc = 0;
    int mon_done_n = 0, mon_done_cyc = 0;
    logic mon_prev = 0;
    int mon_width [MAXB];
    int mon_rise  [MAXB];

    always @(negedge clk) begin
        mon_cyc++;
        if (dout_sel === 1'b1 && !mon_prev) begin
            mon_rise_cyc = mon_cyc;
            mon_hi = 0;
        end
        if (dout_sel === 1'b1) mon_hi++;
        if (dout_sel !== 1'b1 && mon_prev) begin
            if (mon_n < MAXB) begin
                mon_width[mon_n] = mon_hi;
                mon_rise[mon_n]  = mon_rise_cyc;
            end
            mon_n++;
        end
        if (done_sel === 1'b1) begin
            mon_done_n++;
            mon_done_cyc = mon_cyc;
        end
        mon_prev = (dout_sel === 1'b1);
    end

    function automatic logic [31:0] decode_word(input int first, input int nbits);
        logic [31:0] w = '0;
        for (int i = 0; i < nbits; i++) begin
            w = {w[30:0], (first + i < MAXB && mon_width[first+i] == 9)};
        end
        return w;
    endfunction

    // Bad high widths plus rise-to-rise periods other than 15 inside one frame.
    function automatic int frame_errs(input int first, input int nbits);
        int e = 0;
        for (int i = first; i < first + nbits && i < MAXB; i++) begin
            if (mon_width[i] != 4 && mon_width[i] != 9) e++;
            if (i > first && mon_rise[i] - mon_rise[i-1] != 15) e++;
        end
        return e;
    endfunction

    function automatic logic [31:0] model_word(input logic [31:0] px, input int nch,
                                               input logic [7:0] br, input int order);
        int ch [4];
        int t;
        logic [31:0] w = '0;
        for (int i = 0; i < nch; i++) begin
            ch[i] = int'((px >> (8 * (nch - 1 - i))) & 32'hFF);
            ch[i] = (ch[i] * (int'(br) + 1)) / 256;
        end
        if (order == 0) begin
            t = ch[0]; ch[0] = ch[1]; ch[1] = t;
        end
        for (int i = 0; i < nch; i++) w = (w << 8) | 32'(ch[i]);
        return w;
    endfunction

    task automatic pulse_start(input int which, input logic [7:0] br);
        @(negedge clk);
        case (which)
            0: begin start_a = 1; bright_a = br; end
            1: begin start_b = 1; bright_b = br; end
            default: begin start_c = 1; bright_c = br; end
        endcase
        @(negedge clk);
        start_a = 0; start_b = 0; start_c = 0;
    endtask

    task automatic wait_done(input int limit, output bit ok);
        ok = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (done_sel === 1'b1) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int bad = 0;
        rst_a = 1; rst_b = 1; rst_c = 1;
        repeat (2) @(negedge clk);
        checks++;
        if ({dout_a, ready_a, done_a, rd_a, addr_a} !== 5'b0) begin
            errors++; $display("FAIL reset_outputs: got %b expected 00000", {dout_a, ready_a, done_a, rd_a, addr_a});
        end
        checks++;
        if ({ready_b, ready_c, dout_b, dout_c} !== 4'b0) begin
            errors++; $display("FAIL reset_outputs_bc: got %b expected 0000", {ready_b, ready_c, dout_b, dout_c});
        end
        rst_a = 0; rst_b = 0; rst_c = 0;
        for (int k = 1; k < 3600; k++) begin
            @(negedge clk);
            if (ready_a !== 1'b0 || done_a !== 1'b0 || dout_a !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL post_reset_latch: got %0d busy violations expected 0", bad);
        end
        @(negedge clk);
        checks++;
        if ({ready_a, ready_b, ready_c, done_a} !== 4'b1110) begin
            errors++; $display("FAIL ready_after_latch: got %b expected 1110", {ready_a, ready_b, ready_c, done_a});
        end
    endtask

    task automatic test_basic();
        int base, dn0;
        bit ok;
        sel = 0;
        mem_a[0] = 24'hFF0000;
        mem_a[1] = 24'h000001;
        base = mon_n; dn0 = mon_done_n;
        pulse_start(0, 8'd255);
        checks++;
        if ({ready_a, rd_a, addr_a} !== 3'b010) begin
            errors++; $display("FAIL start_accept: got ready,rd,addr=%b expected 010", {ready_a, rd_a, addr_a});
        end
        wait_done(5000, ok);
        repeat (2) @(negedge clk);
        checks++;
        if (!ok) begin errors++; $display("FAIL basic_done: got no done expected done pulse"); end
        checks++;
        if (mon_n - base !== 48) begin errors++; $display("FAIL basic_bits: got %0d expected 48", mon_n - base); end
        checks++;
        if (frame_errs(base, 48) !== 0) begin
            errors++; $display("FAIL basic_timing: got %0d errs expected 0", frame_errs(base, 48));
        end
        checks++;
        if (decode_word(base, 24) !== 32'h0000FF00) begin
            errors++; $display("FAIL basic_px0: got %h expected 0000ff00", decode_word(base, 24));
        end
        checks++;
        if (decode_word(base + 24, 24) !== 32'h00000001) begin
            errors++; $display("FAIL basic_px1: got %h expected 00000001", decode_word(base + 24, 24));
        end
        checks++;
        if (mon_done_cyc - mon_rise[base + 47] !== 3615) begin
            errors++; $display("FAIL latch_len: got %0d expected 3615", mon_done_cyc - mon_rise[base + 47]);
        end
        checks++;
        if (mon_done_n - dn0 !== 1 || ready_a !== 1'b1) begin
            errors++; $display("FAIL basic_done_count: got %0d ready=%b expected 1 ready=1", mon_done_n - dn0, ready_a);
        end
    endtask

    task automatic test_brightness();
        int base;
        bit ok;
        sel = 0;
        base = mon_n;
        pulse_start(0, 8'd127);
        bright_a = 8'd0;
        wait_done(5000, ok);
        repeat (2) @(negedge clk);
        checks++;
        if (!ok || decode_word(base, 24) !== 32'h00007F00 || decode_word(base + 24, 24) !== 32'h0) begin
            errors++; $display("FAIL bright_127: got %h %h expected 00007f00 00000000",
                               decode_word(base, 24), decode_word(base + 24, 24));
        end
        base = mon_n;
        pulse_start(0, 8'd0);
        wait_done(5000, ok);
        repeat (2) @(negedge clk);
        checks++;
        if (!ok || mon_n - base !== 48 || frame_errs(base, 48) !== 0 ||
            decode_word(base, 24) !== 32'h0 || decode_word(base + 24, 24) !== 32'h0) begin
            errors++; $display("FAIL bright_0: got bits=%0d px0=%h px1=%h expected 48 0 0",
                               mon_n - base, decode_word(base, 24), decode_word(base + 24, 24));
        end
    endtask

    task automatic test_back_to_back();
        int base, dn0;
        bit ok1, ok2;
        sel = 0;
        base = mon_n; dn0 = mon_done_n;
        pulse_start(0, 8'd255);
        repeat (100) @(negedge clk);
        pulse_start(0, 8'd255);
        repeat (400) @(negedge clk);
        pulse_start(0, 8'd255);
        repeat (1000) @(negedge clk);
        pulse_start(0, 8'd255);
        wait_done(5000, ok1);
        start_a = 1;
        @(negedge clk);
        start_a = 0;
        checks++;
        if (!ok1 || ready_a !== 1'b0 || rd_a !== 1'b1) begin
            errors++; $display("FAIL start_in_done_cycle: got done=%b ready=%b rd=%b expected 1 0 1", ok1, ready_a, rd_a);
        end
        repeat (200) @(negedge clk);
        pulse_start(0, 8'd255);
        wait_done(5000, ok2);
        repeat (100) @(negedge clk);
        checks++;
        if (!ok2 || mon_done_n - dn0 !== 2 || mon_n - base !== 96 || ready_a !== 1'b1) begin
            errors++; $display("FAIL busy_starts: got dones=%0d bits=%0d ready=%b expected 2 96 1",
                               mon_done_n - dn0, mon_n - base, ready_a);
        end
        checks++;
        if (decode_word(base + 48, 24) !== 32'h0000FF00 || frame_errs(base + 48, 48) !== 0) begin
            errors++; $display("FAIL second_frame: got %h expected 0000ff00", decode_word(base + 48, 24));
        end
    endtask

    task automatic test_reset_mid();
        int base, dn0, bad;
        bit hit;
        sel = 1;
        for (int i = 0; i < 8; i++) mem_b[i] = 24'hFFFFFF;
        base = mon_n; dn0 = mon_done_n;
        pulse_start(1, 8'd255);
        hit = 0;
        for (int i = 0; i < 3000 && !hit; i++) begin
            @(negedge clk);
            if (mon_n - base >= 74 && dout_b === 1'b1) hit = 1;
        end
        rst_b = 1;
        @(negedge clk);
        checks++;
        if (!hit || {dout_b, ready_b, rd_b} !== 3'b000) begin
            errors++; $display("FAIL mid_reset_dout: got hit=%b dout,ready,rd=%b expected 1 000", hit, {dout_b, ready_b, rd_b});
        end
        rst_b = 0;
        bad = 0;
        for (int k = 1; k < 3600; k++) begin
            @(negedge clk);
            if (ready_b !== 1'b0 || done_b !== 1'b0 || dout_b !== 1'b0) bad++;
        end
        @(negedge clk);
        checks++;
        if (bad !== 0 || ready_b !== 1'b1 || done_b !== 1'b0 || mon_done_n !== dn0) begin
            errors++; $display("FAIL mid_reset_latch: got bad=%0d ready=%b dones=%0d expected 0 1 %0d",
                               bad, ready_b, mon_done_n, dn0);
        end
    endtask

    task automatic test_random_latency();
        int base;
        bit ok;
        logic [7:0] br;
        logic [31:0] exp_w;
        sel = 1;
        for (int i = 0; i < 8; i++) mem_b[i] = 24'($urandom);
        br = 8'($urandom_range(1, 254));
        base = mon_n;
        pulse_start(1, br);
        wait_done(8000, ok);
        repeat (2) @(negedge clk);
        checks++;
        if (!ok || mon_n - base !== 192 || frame_errs(base, 192) !== 0) begin
            errors++; $display("FAIL lat4_timing: got done=%b bits=%0d errs=%0d expected 1 192 0",
                               ok, mon_n - base, frame_errs(base, 192));
        end
        for (int p = 0; p < 8; p++) begin
            exp_w = model_word({8'h0, mem_b[p]}, 3, br, 0);
            checks++;
            if (decode_word(base + 24 * p, 24) !== exp_w) begin
                errors++; $display("FAIL lat4_px%0d: got %h expected %h", p, decode_word(base + 24 * p, 24), exp_w);
            end
        end
    endtask

    task automatic test_rgbw();
        int base;
        bit ok;
        sel = 2;
        mem_c[0] = 32'h11223344;
        mem_c[1] = 32'hAABBCCDD;
        base = mon_n;
        pulse_start(2, 8'd255);
        wait_done(5000, ok);
        repeat (2) @(negedge clk);
        checks++;
        if (!ok || mon_n - base !== 64 || frame_errs(base, 64) !== 0) begin
            errors++; $display("FAIL rgbw_timing: got done=%b bits=%0d expected 1 64", ok, mon_n - base);
        end
        checks++;
        if (decode_word(base, 32) !== 32'h11223344 || decode_word(base + 32, 32) !== 32'hAABBCCDD) begin
            errors++; $display("FAIL rgbw_words: got %h %h expected 11223344 aabbccdd",
                               decode_word(base, 32), decode_word(base + 32, 32));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_brightness();
        test_back_to_back();
        test_reset_mid();
        test_random_latency();
        test_rgbw();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
